// File: rtl/mem_pkg.sv
// Shared types and helpers for the burst controller: FSM state encoding,
// default geometry and the wrapping address increment.
package mem_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_REQ,
    RD_REQ,
    RD_HOLD,
    DONE
  } state_t;

  // Wraps to 0 after depth-1, so non-power-of-two depths stay in range.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr + 32'd1 >= depth) ? '0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Single-port memory request bus: the controller is the master and issues one
// word at a time; the memory (slave) completes a request with mem_ready.
interface mem_burst_ctrl_if
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEF_DEPTH)
) ();

  logic                  mem_valid;
  logic                  mem_wr_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]      mem_wdata;
  logic [WIDTH-1:0]      mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_burst_cnt.sv
// Burst address / remaining-length tracker. Loaded at command accept and
// stepped once per completed word; last flags the final word of the burst.
module mem_burst_cnt
  import mem_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH-1:0] addr_next,
  output logic                  last
);

  logic [LEN_WIDTH-1:0] remaining;

  assign addr_next = ADDR_WIDTH'(wrap_inc(32'(addr), DEPTH));
  assign last      = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step) begin
      addr      <= addr_next;
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst master in front of a single-port memory: turns one burst command into
// a sequence of single-word memory requests fed from / drained to streams.
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_data_valid,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_data_ready,
  output logic                  rd_data_valid,
  output logic [WIDTH-1:0]      rd_data,
  input  logic                  rd_data_ready,
  output logic                  busy,
  output logic                  done,
  mem_burst_ctrl_if.master      mem
);

  state_t                state, state_nxt;
  logic                  mem_valid_q, mem_valid_nxt;
  logic                  mem_wr_rd_q, mem_wr_rd_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_nxt;
  logic [WIDTH-1:0]      rd_data_nxt;
  logic                  rd_data_valid_nxt;
  logic                  busy_nxt, done_nxt;
  logic                  cnt_load, cnt_step, cnt_last;
  logic [ADDR_WIDTH-1:0] cnt_addr, cnt_addr_next;
  logic [LEN_WIDTH-1:0]  len_sat;

  function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
    return (len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : len;
  endfunction

  assign len_sat = sat_len(cmd_len);

  // rst gating keeps cmd_ready low while reset is held.
  assign cmd_ready     = (state == IDLE) && !rst;
  assign wr_data_ready = (state == WR_DATA);

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_wr_rd = mem_wr_rd_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  mem_burst_cnt #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .step      (cnt_step),
    .load_addr (cmd_addr),
    .load_len  (len_sat),
    .addr      (cnt_addr),
    .addr_next (cnt_addr_next),
    .last      (cnt_last)
  );

  always_comb begin
    state_nxt         = state;
    mem_valid_nxt     = mem_valid_q;
    mem_wr_rd_nxt     = mem_wr_rd_q;
    mem_addr_nxt      = mem_addr_q;
    mem_wdata_nxt     = mem_wdata_q;
    rd_data_nxt       = rd_data;
    rd_data_valid_nxt = rd_data_valid;
    cnt_load          = 1'b0;
    cnt_step          = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cnt_load = 1'b1;
          if (len_sat == '0) begin
            state_nxt = DONE;
          end else if (cmd_wr) begin
            state_nxt = WR_DATA;
          end else begin
            state_nxt     = RD_REQ;
            mem_valid_nxt = 1'b1;
            mem_wr_rd_nxt = 1'b0;
            mem_addr_nxt  = cmd_addr;
          end
        end
      end
      WR_DATA: begin
        if (wr_data_valid) begin
          state_nxt     = WR_REQ;
          mem_wdata_nxt = wr_data;
          mem_valid_nxt = 1'b1;
          mem_wr_rd_nxt = 1'b1;
          mem_addr_nxt  = cnt_addr;
        end
      end
      WR_REQ: begin
        if (mem.mem_ready) begin
          mem_valid_nxt = 1'b0;
          mem_wr_rd_nxt = 1'b0;
          cnt_step      = 1'b1;
          state_nxt     = cnt_last ? DONE : WR_DATA;
        end
      end
      RD_REQ: begin
        if (mem.mem_ready) begin
          rd_data_nxt       = mem.mem_rdata;
          rd_data_valid_nxt = 1'b1;
          mem_valid_nxt     = 1'b0;
          state_nxt         = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (rd_data_ready) begin
          rd_data_valid_nxt = 1'b0;
          cnt_step          = 1'b1;
          if (cnt_last) begin
            state_nxt = DONE;
          end else begin
            // Next request goes out as the held word leaves, never overlapping it.
            state_nxt     = RD_REQ;
            mem_valid_nxt = 1'b1;
            mem_addr_nxt  = cnt_addr_next;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_valid_q   <= 1'b0;
      mem_wr_rd_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      mem_valid_q   <= mem_valid_nxt;
      mem_wr_rd_q   <= mem_wr_rd_nxt;
      mem_addr_q    <= mem_addr_nxt;
      mem_wdata_q   <= mem_wdata_nxt;
      rd_data       <= rd_data_nxt;
      rd_data_valid <= rd_data_valid_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: directed and random bursts against a memory model
// and a word-level reference of what each burst must do.
module tb_mem_burst_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LW    = 7;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] data;
    int            waits;
  } req_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_wr;
  logic [AW-1:0]    cmd_addr;
  logic [LW-1:0]    cmd_len;
  logic             wr_data_valid, wr_data_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_data_valid, rd_data_ready;
  logic [WIDTH-1:0] rd_data;
  logic             busy, done;

  mem_burst_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) mif ();

  mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_wr        (cmd_wr),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .wr_data_valid (wr_data_valid),
    .wr_data       (wr_data),
    .wr_data_ready (wr_data_ready),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .rd_data_ready (rd_data_ready),
    .busy          (busy),
    .done          (done),
    .mem           (mif)
  );

  always #5 clk = ~clk;

  // Environment state (memory model + monitors)
  logic [WIDTH-1:0] tb_mem [DEPTH];
  req_t             req_q[$];
  logic [WIDTH-1:0] rd_q[$];
  int               done_cnt = 0;
  int               viol = 0;
  int               mem_mode = 0;
  int               rd_mode = 0;
  int               wait_cnt;
  bit               pend;
  logic             prev_wr;
  logic [AW-1:0]    prev_addr;
  logic [WIDTH-1:0] prev_wdata;

  // Bench-side reference
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] wq[$];
  int               n_cmp = 0;
  int               n_fail = 0;

  assign mif.mem_rdata = tb_mem[mif.mem_addr];

  // Memory responder and bus monitor: drive readies on the falling edge,
  // then record what the next rising edge will complete.
  initial begin
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
    mif.mem_ready = 1'b0;
    rd_data_ready = 1'b0;
    wait_cnt = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      case (mem_mode)
        1:       mif.mem_ready = 1'($urandom_range(0, 1));
        2:       mif.mem_ready = (wait_cnt >= 3);
        default: mif.mem_ready = 1'b1;
      endcase
      case (rd_mode)
        1:       rd_data_ready = ~rd_data_ready;
        2:       rd_data_ready = 1'($urandom_range(0, 1));
        default: rd_data_ready = 1'b1;
      endcase
      #1;
      if (done === 1'b1) done_cnt++;
      if (rst === 1'b0) begin
        if (pend && (mif.mem_valid !== 1'b1 || mif.mem_addr !== prev_addr ||
                     mif.mem_wdata !== prev_wdata || mif.mem_wr_rd !== prev_wr))
          viol++;
        if (mif.mem_valid === 1'b1 && rd_data_valid === 1'b1) viol++;
        if (mif.mem_valid === 1'b1 && mif.mem_ready === 1'b1) begin
          req_q.push_back('{wr: mif.mem_wr_rd, addr: mif.mem_addr, data: mif.mem_wdata, waits: wait_cnt});
          if (mif.mem_wr_rd === 1'b1) tb_mem[mif.mem_addr] = mif.mem_wdata;
          wait_cnt = 0;
        end else if (mif.mem_valid === 1'b1) begin
          wait_cnt++;
        end
        if (rd_data_valid === 1'b1 && rd_data_ready === 1'b1) rd_q.push_back(rd_data);
        pend       = (mif.mem_valid === 1'b1) && (mif.mem_ready !== 1'b1);
        prev_addr  = mif.mem_addr;
        prev_wdata = mif.mem_wdata;
        prev_wr    = mif.mem_wr_rd;
      end else begin
        pend = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int sat(input int len);
    return (len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic start_cmd(input bit wr, input int addr, input int len);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin tick(); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic feed_words(input int count);
    int n;
    for (int i = 0; i < count; i++) begin
      wr_data       = wq[i];
      wr_data_valid = 1'b1;
      n = 0;
      while (wr_data_ready !== 1'b1 && n < 200) begin tick(); n++; end
      check("wr_accept", wr_data_ready, 1);
      tick();
    end
    wr_data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin tick(); n++; end
    check("burst_end", busy, 0);
    check("idle_mem", {mif.mem_valid, mif.mem_wr_rd, rd_data_valid}, 0);
  endtask

  task automatic verify(input bit wr, input int addr, input int len, input int d0);
    int L = sat(len);
    int a;
    check("req_count", req_q.size(), L);
    for (int i = 0; i < L && i < req_q.size(); i++) begin
      a = (addr + i) % DEPTH;
      if (wr) begin
        check("wr_req", {req_q[i].wr, req_q[i].addr, req_q[i].data}, {1'b1, AW'(a), wq[i]});
        ref_mem[a] = wq[i];
      end else begin
        check("rd_req", {req_q[i].wr, req_q[i].addr}, {1'b0, AW'(a)});
      end
    end
    if (!wr) begin
      check("rd_count", rd_q.size(), L);
      for (int i = 0; i < L && i < rd_q.size(); i++)
        check("rd_word", rd_q[i], ref_mem[(addr + i) % DEPTH]);
    end
    check("done_pulses", done_cnt - d0, 1);
    check("invariants", viol, 0);
  endtask

  task automatic run_burst(input bit wr, input int addr, input int len);
    int d0;
    req_q.delete();
    rd_q.delete();
    d0 = done_cnt;
    start_cmd(wr, addr, len);
    if (wr) feed_words(sat(len));
    wait_idle();
    verify(wr, addr, len, d0);
  endtask

  initial begin
    int d0, n, wr, addr, len;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0;

    // Reset held two cycles
    tick();
    check("reset_outs_c1", {cmd_ready, wr_data_ready, busy, done, mif.mem_valid, mif.mem_wr_rd,
                            mif.mem_addr, mif.mem_wdata, rd_data_valid, rd_data}, 0);
    tick();
    check("reset_outs_c2", {cmd_ready, wr_data_ready, busy, done, mif.mem_valid, mif.mem_wr_rd,
                            mif.mem_addr, mif.mem_wdata, rd_data_valid, rd_data}, 0);
    rst = 1'b0;
    tick();
    check("post_reset", {cmd_ready, busy}, 2'b10);

    // Directed write, wrap, read with backpressure
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_burst(1, 5, 4);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(WIDTH'($urandom));
    run_burst(1, 62, 4);
    rd_mode = 1;
    run_burst(0, 5, 4);
    rd_mode = 0;

    // Memory stall of three cycles per word
    mem_mode = 2;
    wq = '{16'hA5A5, 16'h5A5A};
    run_burst(1, 30, 2);
    for (int i = 0; i < req_q.size(); i++) check("stall_waits", req_q[i].waits, 3);
    mem_mode = 0;

    // Zero-length command
    req_q.delete();
    d0 = done_cnt;
    start_cmd(1, 7, 0);
    check("len0_done", {done, busy}, 2'b11);
    tick();
    check("len0_idle", {done, busy, cmd_ready}, 3'b001);
    check("len0_noreq", req_q.size(), 0);
    check("len0_pulses", done_cnt - d0, 1);

    // Oversized length saturates to DEPTH
    wq.delete();
    for (int i = 0; i < DEPTH; i++) wq.push_back(WIDTH'($urandom));
    run_burst(1, 10, 100);

    // Reset in the middle of a write burst
    req_q.delete();
    d0 = done_cnt;
    wq = '{16'hBEEF, 16'hCAFE, 16'hF00D, 16'hD00D};
    start_cmd(1, 20, 4);
    feed_words(2);
    n = 0;
    while (req_q.size() < 2 && n < 50) begin tick(); n++; end
    check("midrst_partial", req_q.size(), 2);
    rst = 1'b1;
    tick();
    check("midrst_outs", {cmd_ready, wr_data_ready, busy, done, mif.mem_valid, mif.mem_wr_rd,
                          mif.mem_addr, mif.mem_wdata, rd_data_valid, rd_data}, 0);
    rst = 1'b0;
    tick();
    check("midrst_ready", {cmd_ready, busy}, 2'b10);
    tick();
    check("midrst_nodone", done_cnt - d0, 0);
    ref_mem[20] = 16'hBEEF;
    ref_mem[21] = 16'hCAFE;
    run_burst(0, 19, 4);

    // Random bursts with random memory and read-side backpressure
    mem_mode = 1;
    rd_mode  = 2;
    for (int k = 0; k < 12; k++) begin
      wr   = int'($urandom_range(0, 1));
      addr = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(1, 70));
      wq.delete();
      for (int i = 0; i < sat(len); i++) wq.push_back(WIDTH'($urandom));
      run_burst(wr[0], addr, len);
    end
    run_burst(0, 0, DEPTH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
